// File: rtl/tmr_core.sv
// tmr_core: timer register file with prescaled 32-bit compare/overflow counter
package tmr_pkg;
    typedef enum logic [3:0] {
        TMR_NONE = 4'b0000,
        TMR_CR   = 4'b0001,
        TMR_SR   = 4'b0010,
        TMR_CNTR = 4'b0100,
        TMR_CMPR = 4'b1000
    } tmr_reg_t;
endpackage

module tmr_core import tmr_pkg::*; #(
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  tmr_reg_t    requested_reg,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    logic             en, ie, os, match, ovf;
    logic [PSC_W-1:0] psc, pre;
    logic [31:0]      cntr, cmpr, cr_val, sr_val;
    logic             cr_wr, sr_wr, cntr_wr, cmpr_wr, rd, tick, hit, wrap;

    always_comb begin
        cr_wr   = we && requested_reg == TMR_CR;
        sr_wr   = we && requested_reg == TMR_SR;
        cntr_wr = we && requested_reg == TMR_CNTR;
        cmpr_wr = we && requested_reg == TMR_CMPR;
        rd      = !we && requested_reg != TMR_NONE;
        tick    = en && pre == psc;
        // a software CNTR write discards the tick's match/overflow entirely
        hit     = tick && !cntr_wr && cntr == cmpr;
        wrap    = tick && !cntr_wr && cntr != cmpr && &cntr;
        cr_val  = (32'(psc) << 8) | {29'b0, os, ie, en};
        sr_val  = {30'b0, ovf, match};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            irq   <= 1'b0;
            en    <= 1'b0;
            ie    <= 1'b0;
            os    <= 1'b0;
            psc   <= '0;
            pre   <= '0;
            match <= 1'b0;
            ovf   <= 1'b0;
            cntr  <= '0;
            cmpr  <= '0;
        end else begin
            if (rd)
                rdata <= requested_reg == TMR_CR ? cr_val :
                         requested_reg == TMR_SR ? sr_val :
                         requested_reg == TMR_CNTR ? cntr : cmpr;
            irq   <= ie & (match | ovf);
            pre   <= (cr_wr || !en || tick) ? '0 : pre + PSC_W'(1);
            if (cr_wr) begin
                en  <= wdata[0];
                ie  <= wdata[1];
                os  <= wdata[2];
                psc <= wdata[8+:PSC_W];
            end else if (hit && os) begin
                en  <= 1'b0;
            end
            // hardware set beats a same-cycle W1C
            match <= hit | (match & !(sr_wr & wdata[0]));
            ovf   <= wrap | (ovf & !(sr_wr & wdata[1]));
            if (cntr_wr)
                cntr <= wdata;
            else if (cr_wr && wdata[3])
                cntr <= '0;
            else if (tick)
                cntr <= (hit || wrap) ? '0 : cntr + 32'd1;
            if (cmpr_wr)
                cmpr <= wdata;
        end
    end
endmodule

// File: tb/tb_tmr_core.sv
// tb_tmr_core: directed table, corner sequences and randomized model check for tmr_core
module tb_tmr_core;
    import tmr_pkg::*;

    typedef struct {
        tmr_reg_t    sel;
        logic        we;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ei;
    } vec_t;

    localparam logic [31:0] CR_MASK = 32'h0000_FF07;

    logic        clk = 1'b0;
    logic        rst;
    tmr_reg_t    sel;
    logic        we;
    logic [31:0] wdata, rdata;
    logic        irq;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_cr, m_sr, m_cntr, m_cmpr, m_rdata;
    int          m_pre;
    logic        m_irq;

    vec_t tv[16];
    int   nv = 0;

    always #5 clk = ~clk;

    tmr_core dut (
        .clk(clk), .rst(rst), .requested_reg(sel), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cr = 0; m_sr = 0; m_cntr = 0; m_cmpr = 0; m_rdata = 0; m_pre = 0; m_irq = 0;
    endtask

    task automatic model_step(input tmr_reg_t s, input logic w, input logic [31:0] d);
        logic        tick, cw;
        logic [31:0] n_cr, n_sr, n_cntr, set;
        tick   = m_cr[0] && m_pre == int'(m_cr[15:8]);
        cw     = w && s == TMR_CNTR;
        n_cr   = m_cr;
        n_sr   = m_sr;
        n_cntr = m_cntr;
        set    = 0;
        if (s != TMR_NONE && !w)
            m_rdata = s == TMR_CR ? m_cr : s == TMR_SR ? m_sr : s == TMR_CNTR ? m_cntr : m_cmpr;
        if (tick && !cw) begin
            if (m_cntr == m_cmpr) begin
                set = 1; n_cntr = 0;
                if (m_cr[2]) n_cr[0] = 1'b0;
            end else if (m_cntr == 32'hFFFF_FFFF) begin
                set = 2; n_cntr = 0;
            end else n_cntr = m_cntr + 1;
        end
        m_irq = m_cr[1] && m_sr != 0;
        m_pre = ((w && s == TMR_CR) || !m_cr[0] || tick) ? 0 : m_pre + 1;
        if (w) begin
            case (s)
                TMR_CR:   begin n_cr = d & CR_MASK; if (d[3]) n_cntr = 0; end
                TMR_SR:   n_sr = m_sr & ~d & 32'h3;
                TMR_CNTR: n_cntr = d;
                TMR_CMPR: m_cmpr = d;
                default:  ;
            endcase
        end
        m_cr = n_cr; m_sr = n_sr | set; m_cntr = n_cntr;
    endtask

    task automatic cyc(input tmr_reg_t s, input logic w, input logic [31:0] d);
        sel = s; we = w; wdata = d;
        @(posedge clk);
        model_step(s, w, d);
        #1;
    endtask

    task automatic rdchk(input string name, input tmr_reg_t s, input logic [31:0] exp);
        cyc(s, 1'b0, 32'h0);
        check(name, rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; sel = TMR_NONE; we = 1'b0; wdata = 0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic add(input tmr_reg_t s, input logic w, input logic [31:0] d,
                       input logic [31:0] er, input logic ei);
        tv[nv] = '{s, w, d, er, ei};
        nv++;
    endtask

    initial begin
        tmr_reg_t regs[5] = '{TMR_NONE, TMR_CR, TMR_SR, TMR_CNTR, TMR_CMPR};
        add(TMR_CR,   0, 0, 0, 0);
        add(TMR_SR,   0, 0, 0, 0);
        add(TMR_CNTR, 0, 0, 0, 0);
        add(TMR_CMPR, 0, 0, 0, 0);
        add(TMR_CMPR, 1, 4, 0, 0);
        add(TMR_CR,   1, 3, 0, 0);
        add(TMR_CNTR, 0, 0, 0, 0);
        add(TMR_CNTR, 0, 0, 1, 0);
        add(TMR_CNTR, 0, 0, 2, 0);
        add(TMR_CNTR, 0, 0, 3, 0);
        add(TMR_CNTR, 0, 0, 4, 0);
        add(TMR_CNTR, 0, 0, 0, 1);
        add(TMR_SR,   0, 0, 1, 1);
        add(TMR_SR,   1, 1, 1, 1);
        add(TMR_SR,   0, 0, 0, 0);
        add(TMR_CNTR, 0, 0, 4, 0);

        do_reset();
        check("reset_rdata", rdata, 0);
        check("reset_irq", {31'b0, irq}, 0);
        for (int i = 0; i < nv; i++) begin
            cyc(tv[i].sel, tv[i].we, tv[i].wd);
            check($sformatf("tab%0d_rdata", i), rdata, tv[i].er);
            check($sformatf("tab%0d_irq", i), {31'b0, irq}, {31'b0, tv[i].ei});
        end

        do_reset();
        cyc(TMR_CMPR, 1, 2);
        cyc(TMR_CR, 1, 32'h301);
        for (int i = 0; i < 5; i++) rdchk($sformatf("psc3_cntr%0d", i), TMR_CNTR, i == 4 ? 1 : 0);

        do_reset();
        cyc(TMR_CMPR, 1, 32'h10);
        cyc(TMR_CNTR, 1, 32'hFFFF_FFFE);
        cyc(TMR_CR, 1, 1);
        rdchk("ovf_cntr_fe", TMR_CNTR, 32'hFFFF_FFFE);
        rdchk("ovf_cntr_ff", TMR_CNTR, 32'hFFFF_FFFF);
        rdchk("ovf_sr", TMR_SR, 2);
        rdchk("ovf_cntr_after", TMR_CNTR, 1);

        do_reset();
        cyc(TMR_CMPR, 1, 2);
        cyc(TMR_CR, 1, 5);
        repeat (4) cyc(TMR_NONE, 0, 0);
        rdchk("os_cr", TMR_CR, 4);
        rdchk("os_cntr", TMR_CNTR, 0);
        rdchk("os_sr", TMR_SR, 1);
        cyc(TMR_CR, 1, 9);
        rdchk("os_restart0", TMR_CNTR, 0);
        rdchk("os_restart1", TMR_CNTR, 1);
        check("os_irq", {31'b0, irq}, 0);

        do_reset();
        cyc(TMR_CMPR, 1, 32'hFFFF);
        cyc(TMR_CR, 1, 1);
        cyc(TMR_CNTR, 1, 32'h100);
        rdchk("cntr_wr_vs_tick", TMR_CNTR, 32'h100);

        do_reset();
        cyc(TMR_CMPR, 1, 2);
        cyc(TMR_CR, 1, 1);
        cyc(TMR_NONE, 0, 0);
        cyc(TMR_NONE, 0, 0);
        cyc(TMR_SR, 1, 1);
        rdchk("w1c_vs_match", TMR_SR, 1);
        rdchk("none_pre", TMR_CMPR, 2);
        cyc(TMR_NONE, 1, 32'hDEAD);
        check("none_rdata_hold", rdata, 2);
        rdchk("none_cmpr", TMR_CMPR, 2);

        do_reset();
        check("midreset_irq", {31'b0, irq}, 0);
        rdchk("midreset_cntr", TMR_CNTR, 0);
        rdchk("midreset_cr", TMR_CR, 0);

        for (int i = 0; i < 3000; i++) begin
            tmr_reg_t    s;
            logic        w;
            logic [31:0] d;
            s = regs[$urandom_range(0, 4)];
            w = $urandom_range(0, 9) < 3;
            d = $urandom;
            case (s)
                TMR_CR:   d = {16'h0, 8'($urandom_range(0, 3)), 4'h0, d[3:1], 1'($urandom_range(0, 3) != 0)} | (d & 32'hFFFF_0000);
                TMR_SR:   d = d & 32'h3;
                TMR_CNTR: d = d[0] ? 32'hFFFF_FFF0 + (d & 32'hF) : (d & 32'hF);
                TMR_CMPR: d = d[0] ? 32'hFFFF_FFFF : (d & 32'h1F);
                default:  ;
            endcase
            cyc(s, w, d);
            check("rand_rdata", rdata, m_rdata);
            check("rand_irq", {31'b0, irq}, {31'b0, m_irq});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
